// File: rtl/fpcvt_result_buf.sv
// rtl/fpcvt_result_buf.sv - result queue between the FP-to-int converter and integer writeback
// Circular FIFO of {data, alt, tag} with registered skid stall and a sticky overflow flag.
module fpcvt_result_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    parameter int TAGW  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_alt,
    input  logic [TAGW-1:0]          in_tag,
    input  logic                     flush,
    input  logic                     out_rdy,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_alt,
    output logic [TAGW-1:0]          out_tag,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] L_HIGH = CW'(DEPTH - 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic             r_alt  [DEPTH];
    logic [TAGW-1:0]  r_tag  [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_stall;
    logic             r_ovf;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CW-1:0]    w_count_nxt;

    assign out_vld = (r_count != '0);
    assign w_full  = (r_count == L_FULL);
    assign w_pop   = out_vld & out_rdy & ~flush;
    // A full queue still accepts a result when the head leaves in the same cycle.
    assign w_push  = in_en & ~flush & (~w_full | w_pop);
    assign w_drop  = in_en & ~flush & w_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            // Raised one entry early so the converter stage has a cycle of skid.
            r_stall <= (w_count_nxt >= L_HIGH);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_data[r_wr_ptr] <= in_data;
            r_alt[r_wr_ptr]  <= in_alt;
            r_tag[r_wr_ptr]  <= in_tag;
        end
    end

    assign out_data = out_vld ? r_data[r_rd_ptr] : '0;
    assign out_alt  = out_vld ? r_alt[r_rd_ptr]  : 1'b0;
    assign out_tag  = out_vld ? r_tag[r_rd_ptr]  : '0;
    assign stall    = r_stall;
    assign count    = r_count;
    assign ovf      = r_ovf;
endmodule

// File: tb/tb_fpcvt_result_buf.sv
// tb/tb_fpcvt_result_buf.sv - self-checking bench for fpcvt_result_buf
module tb_fpcvt_result_buf;
    localparam int DEPTH = 4;
    localparam int WIDTH = 65;
    localparam int TAGW  = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_en = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_alt = 1'b0;
    logic [TAGW-1:0]  in_tag = '0;
    logic             flush = 1'b0;
    logic             out_rdy = 1'b0;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_alt;
    logic [TAGW-1:0]  out_tag;
    logic             stall;
    logic [2:0]       count;
    logic             ovf;

    int checks = 0;
    int failures = 0;

    fpcvt_result_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .in_alt(in_alt),
        .in_tag(in_tag), .flush(flush), .out_rdy(out_rdy), .out_vld(out_vld),
        .out_data(out_data), .out_alt(out_alt), .out_tag(out_tag), .stall(stall),
        .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             a;
        logic [TAGW-1:0]  t;
    } ent_t;

    ent_t mq[$];
    logic m_ovf = 1'b0;
    logic m_stall = 1'b0;
    bit   m_valid = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue semantics evaluated from the pre-edge inputs.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_stall = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (flush) begin
                mq.delete();
                m_stall = 1'b0;
            end else begin
                bit pop, full, push;
                ent_t e;
                pop  = (mq.size() > 0) && out_rdy;
                full = (mq.size() == DEPTH);
                push = in_en && (!full || pop);
                if (in_en && full && !pop) m_ovf = 1'b1;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.d = in_data;
                    e.a = in_alt;
                    e.t = in_tag;
                    mq.push_back(e);
                end
                m_stall = (mq.size() >= DEPTH - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_vld", 128'(out_vld), 128'(mq.size() != 0));
            chk("m_count", 128'(count), 128'(mq.size()));
            chk("m_stall", 128'(stall), 128'(m_stall));
            chk("m_ovf", 128'(ovf), 128'(m_ovf));
            chk("m_data", 128'(out_data), mq.size() != 0 ? 128'(mq[0].d) : 128'(0));
            chk("m_alt", 128'(out_alt), mq.size() != 0 ? 128'(mq[0].a) : 128'(0));
            chk("m_tag", 128'(out_tag), mq.size() != 0 ? 128'(mq[0].t) : 128'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_set(input int tag);
        in_en   = 1'b1;
        in_tag  = TAGW'(tag);
        in_data = WIDTH'(tag) * 65'd7 + 65'h1_0000_0000_0000_0000;
        in_alt  = tag[0];
    endtask

    task automatic drain();
        in_en = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        out_rdy = 1'b0;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        chk("rst_vld", 128'(out_vld), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));

        // Single push, one-cycle latency
        in_en = 1'b1; in_data = 65'h1_0000_0000_0000_0005; in_tag = 9'h21; in_alt = 1'b1;
        tick();
        in_en = 1'b0;
        chk("lat_vld", 128'(out_vld), 128'(1));
        chk("lat_data", 128'(out_data), 128'(65'h1_0000_0000_0000_0005));
        chk("lat_tag", 128'(out_tag), 128'(9'h21));
        chk("lat_alt", 128'(out_alt), 128'(1));
        chk("lat_count", 128'(count), 128'(1));
        drain();

        // Fill and overflow
        for (int t = 1; t <= 4; t++) begin
            push_set(t);
            tick();
        end
        chk("full_count", 128'(count), 128'(4));
        chk("full_stall", 128'(stall), 128'(1));
        push_set(5);
        tick();
        in_en = 1'b0;
        chk("ovf_set", 128'(ovf), 128'(1));
        chk("ovf_count", 128'(count), 128'(4));
        chk("ovf_head", 128'(out_tag), 128'(1));
        drain();

        // Streaming push+pop across pointer wrap
        push_set(10);
        tick();
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_set(11 + i);
            tick();
            chk("str_count", 128'(count), 128'(1));
            chk("str_stall", 128'(stall), 128'(0));
            chk("str_tag", 128'(out_tag), 128'(11 + i));
        end
        drain();

        // Flush with same-cycle in_en
        for (int t = 30; t <= 32; t++) begin
            push_set(t);
            tick();
        end
        chk("pre_flush_count", 128'(count), 128'(3));
        push_set(33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_en = 1'b0;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_vld", 128'(out_vld), 128'(0));
        chk("flush_stall", 128'(stall), 128'(0));
        chk("flush_ovf", 128'(ovf), 128'(1));

        // Reset mid-stream
        push_set(40); tick();
        push_set(41); tick();
        push_set(42);
        out_rdy = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_rdy = 1'b0;
        chk("mrst_count", 128'(count), 128'(0));
        chk("mrst_ovf", 128'(ovf), 128'(0));
        chk("mrst_vld", 128'(out_vld), 128'(0));
        push_set(43);
        tick();
        in_en = 1'b0;
        chk("post_rst_vld", 128'(out_vld), 128'(1));
        chk("post_rst_tag", 128'(out_tag), 128'(43));
        drain();

        // Full queue with same-cycle pop and push
        for (int t = 50; t <= 53; t++) begin
            push_set(t);
            tick();
        end
        push_set(54);
        out_rdy = 1'b1;
        tick();
        in_en = 1'b0;
        chk("fpp_count", 128'(count), 128'(4));
        chk("fpp_ovf", 128'(ovf), 128'(0));
        chk("fpp_head", 128'(out_tag), 128'(51));
        tick();
        tick();
        tick();
        chk("fpp_fourth", 128'(out_tag), 128'(54));
        tick();
        out_rdy = 1'b0;
        chk("fpp_empty", 128'(count), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpcvt_result_buf.md
FPCVT_RESULT_BUF -- requirements
Module: fpcvt_result_buf

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are 2, 4 and 8.
REQ-002 The module SHALL have parameter WIDTH, default 65, meaning the result width (matches the FP-to-int converter result).
REQ-003 The module SHALL have parameter TAGW, default 9, meaning the destination register tag width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port in_en, input, 1 bit: converter result valid this cycle.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: converter result.
REQ-008 The module SHALL have port in_alt, input, 1 bit: converter alternate-route flag.
REQ-009 The module SHALL have port in_tag, input, TAGW bits: destination tag of the result.
REQ-010 The module SHALL have port flush, input, 1 bit: pipeline flush; discards all held results.
REQ-011 The module SHALL have port out_rdy, input, 1 bit: integer writeback port grants a pop.
REQ-012 The module SHALL have port out_vld, output, 1 bit: head entry valid.
REQ-013 The module SHALL have port out_data, output, WIDTH bits: head result.
REQ-014 The module SHALL have port out_alt, output, 1 bit: head alternate-route flag.
REQ-015 The module SHALL have port out_tag, output, TAGW bits: head destination tag.
REQ-016 The module SHALL have port stall, output, 1 bit: asks upstream to deassert the converter clock enable.
REQ-017 The module SHALL have port count, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-018 The module SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-019 The block SHALL be a circular FIFO of DEPTH entries {data, alt, tag}, with a write pointer, a read pointer and an occupancy counter.
REQ-020 A push SHALL occur when in_en=1, flush=0 and count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-021 A pop SHALL occur when out_vld=1, out_rdy=1 and flush=0.
REQ-022 Latency SHALL be 1 cycle: a result pushed at edge N is presented on out_* from cycle N+1 when the queue was empty.
REQ-023 out_vld SHALL equal (count!=0); out_data, out_alt and out_tag SHALL be the entry at the read pointer.
REQ-024 When out_vld=0, out_data, out_alt and out_tag SHALL be 0.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Pointers SHALL wrap modulo DEPTH; entry order SHALL be strictly FIFO across wrap.
REQ-027 A push attempted when count==DEPTH with no pop SHALL be dropped, and ovf SHALL be set until reset; state SHALL be otherwise unchanged.
REQ-028 stall SHALL be registered and equal 1 in the cycle after the one where next-count >= DEPTH-1, giving one cycle of skid for the converter stage.
REQ-029 flush=1 SHALL, at the next edge, zero count and both pointers and clear stall; a same-cycle in_en is discarded.
REQ-030 flush SHALL NOT clear ovf.
REQ-031 The block SHALL NOT modify data or tag; out_alt SHALL pass in_alt unchanged.

Reset
REQ-032 With rst=1 at an edge, count, pointers, stall and ovf SHALL be 0, and out_vld=0 with out_data/out_alt/out_tag=0 in the following cycle.
REQ-033 rst SHALL take priority over flush, push and pop; stored entry contents need not be cleared.
REQ-034 Deasserting rst SHALL allow a push on the very next edge.

Verification
REQ-035 The bench SHALL push 0x1_0000_0000_0000_0005 with tag 0x21 and alt=1 into an empty queue with out_rdy=0; next cycle out_vld=1, out_data=0x1_0000_0000_0000_0005, out_tag=0x21, out_alt=1, count=1.
REQ-036 The bench SHALL push 4 entries with tags 1..4 while out_rdy=0; count=4 and stall=1; a 5th push sets ovf=1, count stays 4, and out_tag=1.
REQ-037 The bench SHALL push and pop every cycle for 10 cycles starting with 1 entry; count stays 1, tags exit in push order across pointer wrap, and stall=0.
REQ-038 The bench SHALL hold 3 entries, then assert flush together with in_en; next cycle count=0, out_vld=0, stall=0, and ovf is unchanged.
REQ-039 The bench SHALL assert rst mid-stream with 2 entries, ovf=1 and out_rdy=1; next cycle count=0, ovf=0, out_vld=0, and a push on the following edge appears one cycle later.
REQ-040 The bench SHALL perform a full queue plus a same-cycle pop and push; count stays 4, no ovf, and the new entry emerges 4th.
